// File: rtl/grid_scan_7x7.sv
`default_nettype none
// ============================================================================
//  Module   : grid_scan_7x7
//  Purpose  : Row-multiplexed scanner for a 7x7 cell grid. A snapshot of the
//             grid is taken once per frame, then each row is driven for DWELL
//             cycles followed by BLANK all-off cycles. frame_done pulses on
//             the last cycle of each frame.
//  Options  : SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that gates
//             col_data on a period-8 duty cycle within each row dwell.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_scan_7x7 #(
  parameter int DWELL = 1000,
  parameter int BLANK = 8
) (
  input  logic        clka,
  input  logic        stop,
  input  logic        enable,
  input  logic [48:0] grid,
  input  logic        grid_valid,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0]  brightness,
`endif
  output logic [6:0]  row_sel,
  output logic [6:0]  col_data,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_BLANK = 2'd3
  } state_t;

  // Last in-state count for each timed state; 16 bits covers DWELL up to 65535.
  localparam logic [15:0] c_dwell_last = 16'(DWELL - 1);
  localparam logic [15:0] c_blank_last = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
  localparam bit          c_has_blank  = (BLANK > 0);

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] cnt_q, cnt_d;
  logic [48:0] snap_q, snap_d;
  logic        pending_q, pending_d;
  logic [6:0]  row_sel_q, row_sel_d;
  logic [6:0]  col_data_q, col_data_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic        w_row_end;
  logic        w_last_cyc;
  logic [5:0]  w_base;

  // Next-state, counters, snapshot and pending-flag update.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    w_row_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grid_valid) pending_d = 1'b1;
        // Entering LOAD from IDLE must always refresh the snapshot, so it is
        // treated as if a new generation were pending.
        if (enable) begin
          state_d   = ST_LOAD;
          pending_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (pending_q || grid_valid) snap_d = grid;
        pending_d = 1'b0;
        row_d     = 3'd0;
        cnt_d     = 16'd0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        if (grid_valid) pending_d = 1'b1;
        if (cnt_q == c_dwell_last) begin
          if (c_has_blank) begin
            state_d = ST_BLANK;
            cnt_d   = 16'd0;
          end else begin
            w_row_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BLANK: begin
        if (grid_valid) pending_d = 1'b1;
        if (cnt_q == c_blank_last) w_row_end = 1'b1;
        else                       cnt_d = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Row finished: advance to the next row, or close the frame.
    if (w_row_end) begin
      cnt_d = 16'd0;
      if (row_q == 3'd6) begin
        row_d   = 3'd0;
        state_d = enable ? ST_LOAD : ST_IDLE;
      end else begin
        row_d   = row_q + 3'd1;
        state_d = ST_SCAN;
      end
    end
  end

  // Output values for the upcoming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    row_sel_d  = 7'd0;
    col_data_d = 7'd0;
    w_base     = {3'b000, row_d} * 6'd7;
    if (state_d == ST_SCAN) begin
      row_sel_d  = 7'd1 << row_d;
      col_data_d = snap_d[w_base +: 7];
`ifdef SCAN_BRIGHTNESS_EN
      if (cnt_d[2:0] > brightness) col_data_d = 7'd0;
`endif
    end
    if (c_has_blank) w_last_cyc = (state_d == ST_BLANK) && (cnt_d == c_blank_last);
    else             w_last_cyc = (state_d == ST_SCAN)  && (cnt_d == c_dwell_last);
    frame_done_d  = w_last_cyc && (row_d == 3'd6);
    frame_count_d = frame_count_q + {7'd0, frame_done_d};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clka) begin
    if (stop) begin
      state_q       <= ST_IDLE;
      row_q         <= 3'd0;
      cnt_q         <= 16'd0;
      snap_q        <= 49'd0;
      pending_q     <= 1'b0;
      row_sel_q     <= 7'd0;
      col_data_q    <= 7'd0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      snap_q        <= snap_d;
      pending_q     <= pending_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_scan_7x7.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_scan_7x7
//  Purpose  : Self-checking bench for grid_scan_7x7. Two instances share the
//             stimulus: A (DWELL=4, BLANK=2) and B (DWELL=16, BLANK=0).
//             A frame-position model predicts every output each cycle;
//             directed literal checks pin the model's timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_scan_7x7;

  logic        clka = 1'b0;
  logic        stop, enable, grid_valid;
  logic [48:0] grid;
  logic [2:0]  brightness;

  logic [6:0]  a_rs, a_cd, b_rs, b_cd;
  logic        a_fd, b_fd;
  logic [7:0]  a_fc, b_fc;

  always #5 clka = ~clka;

  grid_scan_7x7 #(.DWELL(4), .BLANK(2)) dut_a (
    .clka(clka), .stop(stop), .enable(enable), .grid(grid), .grid_valid(grid_valid),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .row_sel(a_rs), .col_data(a_cd), .frame_done(a_fd), .frame_count(a_fc)
  );

  grid_scan_7x7 #(.DWELL(16), .BLANK(0)) dut_b (
    .clka(clka), .stop(stop), .enable(enable), .grid(grid), .grid_valid(grid_valid),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .row_sel(b_rs), .col_data(b_cd), .frame_done(b_fd), .frame_count(b_fc)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by its position m_t inside the frame
  // (0 = LOAD cycle, 1..len-1 = row slots) or by being idle.
  int          md [2] = '{4, 16};
  int          mb [2] = '{2, 0};
  bit          m_ok = 1'b0;
  bit          m_act  [2];
  int          m_t    [2];
  logic [48:0] m_snap [2];
  bit          m_pend [2];
  bit          m_fidle[2];
  logic [7:0]  m_cnt  [2];
  logic [2:0]  m_br = 3'd7;

  task automatic model_step(input int i);
    int len;
    len = 1 + 7 * (md[i] + mb[i]);
    if (stop) begin
      m_act[i] = 0; m_t[i] = 0; m_snap[i] = '0; m_pend[i] = 0;
      m_fidle[i] = 0; m_cnt[i] = 8'd0;
    end else if (!m_act[i]) begin
      if (grid_valid) m_pend[i] = 1;
      if (enable) begin m_act[i] = 1; m_t[i] = 0; m_fidle[i] = 1; end
    end else if (m_t[i] == 0) begin
      if (m_pend[i] || m_fidle[i] || grid_valid) m_snap[i] = grid;
      m_pend[i] = 0; m_fidle[i] = 0; m_t[i] = 1;
    end else begin
      if (grid_valid) m_pend[i] = 1;
      if (m_t[i] == len - 1) begin
        if (enable) m_t[i] = 0;
        else        m_act[i] = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] == len - 1) m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end
  endtask

  task automatic model_out(input int i, output logic [6:0] rs, output logic [6:0] cd,
                           output logic fd, output logic [7:0] fc);
    int per, p, row, ph, len;
    len = 1 + 7 * (md[i] + mb[i]);
    rs = '0; cd = '0; fd = 1'b0; fc = m_cnt[i];
    if (m_act[i] && m_t[i] != 0) begin
      per = md[i] + mb[i];
      p   = m_t[i] - 1;
      row = p / per;
      ph  = p % per;
      if (ph < md[i]) begin
        rs = 7'(1 << row);
        cd = 7'((m_snap[i] >> (7 * row)) & 49'h7F);
        if ((ph % 8) > int'(m_br)) cd = '0;
      end
      fd = (m_t[i] == len - 1);
    end
  endtask

  always @(posedge clka) begin
    if (stop) m_ok = 1'b1;
    model_step(0);
    model_step(1);
`ifdef SCAN_BRIGHTNESS_EN
    m_br = brightness;
`endif
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clka) begin
    logic [6:0] ers, ecd;
    logic       efd;
    logic [7:0] efc;
    if (m_ok) begin
      model_out(0, ers, ecd, efd, efc);
      check("a.row_sel",     64'(a_rs), 64'(ers));
      check("a.col_data",    64'(a_cd), 64'(ecd));
      check("a.frame_done",  64'(a_fd), 64'(efd));
      check("a.frame_count", 64'(a_fc), 64'(efc));
      check("a.onehot",      64'($countones(a_rs) <= 1), 64'd1);
      model_out(1, ers, ecd, efd, efc);
      check("b.row_sel",     64'(b_rs), 64'(ers));
      check("b.col_data",    64'(b_cd), 64'(ecd));
      check("b.frame_done",  64'(b_fd), 64'(efd));
      check("b.frame_count", 64'(b_fc), 64'(efc));
      check("b.onehot",      64'($countones(b_rs) <= 1), 64'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic adv(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic wait_fd(input int bound);
    int k;
    k = 0;
    @(negedge clka);
    while (!a_fd && k < bound) begin
      @(negedge clka);
      k++;
    end
    n_vec++;
    if (!a_fd) begin
      n_bad++;
      $display("FAIL wait_frame_done: no pulse within %0d cycles", bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] all_ones;
    all_ones   = {49{1'b1}};
    stop       = 1'b1;
    enable     = 1'b0;
    grid       = '0;
    grid_valid = 1'b0;
    brightness = 3'd7;
    adv(3);
    check("reset.row_sel",     64'(a_rs), 64'd0);
    check("reset.col_data",    64'(a_cd), 64'd0);
    check("reset.frame_count", 64'(a_fc), 64'd0);

    // Basic frame timing: cycle 0 = first IDLE cycle with enable high.
    stop = 1'b0; enable = 1'b1; grid = 49'h1;
    for (int k = 0; k <= 113; k++) begin
      if (k > 0) @(negedge clka);
      if (k == 1) check("a.load_rowsel", 64'(a_rs), 64'd0);
      if (k >= 2 && k <= 5) begin
        check("a.row0_sel", 64'(a_rs), 64'h01);
        check("a.row0_col", 64'(a_cd), 64'h01);
      end
      if (k == 6 || k == 7) check("a.blank_sel", 64'(a_rs), 64'd0);
      if (k == 42) check("a.fd_early", 64'(a_fd), 64'd0);
      if (k == 43) begin
        check("a.fd_43", 64'(a_fd), 64'd1);
        check("a.fc_43", 64'(a_fc), 64'd1);
      end
      if (k == 17) check("b.row0_sel", 64'(b_rs), 64'h01);
      if (k == 18) check("b.row1_nogap", 64'(b_rs), 64'h02);
      if (k == 112) check("b.fd_early", 64'(b_fd), 64'd0);
      if (k == 113) begin
        check("b.fd_113", 64'(b_fd), 64'd1);
        check("b.fc_113", 64'(b_fc), 64'd1);
      end
    end

    // New grid appears without grid_valid, then grid_valid mid-frame.
    grid = 49'h7F << 42;
    wait_fd(100);
    adv(10);
    grid_valid = 1'b1;
    adv(1);
    grid_valid = 1'b0;
    adv(27);
    check("a.old_frame_sel", 64'(a_rs), 64'h40);
    check("a.old_frame_col", 64'(a_cd), 64'h00);
    wait_fd(100);
    adv(2);
    check("a.new_row0_col", 64'(a_cd), 64'h00);
    adv(36);
    check("a.new_row6_sel", 64'(a_rs), 64'h40);
    check("a.new_row6_col", 64'(a_cd), 64'h7F);

    // Grid change without grid_valid must never be displayed.
    grid = all_ones;
    wait_fd(100);
    adv(2);
    check("a.nogv_row0_col", 64'(a_cd), 64'h00);
    adv(36);
    check("a.nogv_row6_col", 64'(a_cd), 64'h7F);

    // enable dropped during row 2: frame completes, then IDLE.
    wait_fd(100);
    adv(15);
    enable = 1'b0;
    adv(28);
    check("a.drop_fd", 64'(a_fd), 64'd1);
    adv(1);
    check("a.idle_sel", 64'(a_rs), 64'd0);
    check("a.idle_col", 64'(a_cd), 64'd0);
    check("a.idle_fd",  64'(a_fd), 64'd0);
    adv(2);
    check("a.idle_sel2", 64'(a_rs), 64'd0);

    // Restart, then stop during row 4 with enable/grid_valid also high.
    enable = 1'b1;
    adv(1);
    adv(26);
    check("a.row4_sel", 64'(a_rs), 64'h10);
    stop = 1'b1; grid_valid = 1'b1;
    adv(1);
    check("a.abort_sel", 64'(a_rs), 64'd0);
    check("a.abort_col", 64'(a_cd), 64'd0);
    check("a.abort_fd",  64'(a_fd), 64'd0);
    check("a.abort_fc",  64'(a_fc), 64'd0);
    check("b.abort_fc",  64'(b_fc), 64'd0);
    adv(1);
    check("a.stop_prio_sel", 64'(a_rs), 64'd0);
    stop = 1'b0; grid_valid = 1'b0; enable = 1'b0;
    adv(5);

`ifdef SCAN_BRIGHTNESS_EN
    // Duty-cycle gating on instance B (DWELL=16): row 0 spans cycles 2..17.
    for (int pass = 0; pass < 2; pass++) begin
      int nz;
      nz = 0;
      brightness = (pass == 0) ? 3'd1 : 3'd7;
      grid = all_ones;
      stop = 1'b1;
      adv(1);
      stop = 1'b0; enable = 1'b1;
      for (int k = 0; k <= 17; k++) begin
        if (k > 0) @(negedge clka);
        if (k >= 2 && b_cd != 7'd0) nz++;
      end
      check(pass == 0 ? "b.bright1_on" : "b.bright7_on", 64'(nz), (pass == 0) ? 64'd4 : 64'd16);
      enable = 1'b0;
      adv(2);
    end
`endif

    adv(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grid_scan_7x7.md
GRID_SCAN_7X7 -- requirements
Module: grid_scan_7x7

Interface
REQ-001 SHALL have parameter DWELL, default 1000, cycles each row is driven (legal range 2..65535).
REQ-002 SHALL have parameter BLANK, default 8, all-off cycles between rows (legal range 0..255; 0 removes the blanking gap).
REQ-003 SHALL have port clka, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port stop, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit, scanning requested.
REQ-006 SHALL have port grid, input, 49 bits; cell (r,c) is bit 7r+c.
REQ-007 SHALL have port grid_valid, input, 1 bit; a one-cycle pulse means a new generation is present on grid.
REQ-008 SHALL have port row_sel, output, 7 bits; one-hot, active-high row drive.
REQ-009 SHALL have port col_data, output, 7 bits; col_data[c] is the cell of the active row.
REQ-010 SHALL have port frame_done, output, 1 bit; one-cycle pulse at the end of each frame.
REQ-011 SHALL have port frame_count, output, 8 bits; count of completed frames, wraps 255->0.

Function
REQ-012 SHALL implement the states IDLE, LOAD, SCAN and BLANK.
REQ-013 IDLE: row_sel=0 and col_data=0; moves to LOAD when enable=1.
REQ-014 LOAD: lasts 1 cycle; snap<=grid if pending=1 or LOAD was entered from IDLE, otherwise snap is unchanged; pending is cleared; row=0; goes to SCAN.
REQ-015 SCAN: lasts exactly DWELL cycles; row_sel = 1<<row; col_data = snap[7*row+6 : 7*row].
REQ-016 BLANK: lasts exactly BLANK cycles with row_sel=0 and col_data=0; when BLANK=0 the state is skipped.
REQ-017 After the SCAN or BLANK of rows 0..5: row increments and the block returns to SCAN.
REQ-018 After the SCAN or BLANK of row 6: frame_done=1 for 1 cycle and frame_count increments. The next state is LOAD if enable=1, otherwise IDLE.
REQ-019 Frame period SHALL be 1 + 7*(DWELL+BLANK) cycles.
REQ-020 grid_valid=1 in any state other than LOAD sets pending.
REQ-021 grid_valid=1 during the LOAD cycle loads grid that cycle and leaves pending cleared.
REQ-022 snap SHALL never change except in LOAD, so a frame is never torn.
REQ-023 enable deasserted mid-frame: the current frame completes, including frame_done, and then the block enters IDLE. Outputs are never cut mid-row.
REQ-024 row_sel SHALL never have more than one bit set in any cycle.
REQ-025 The dwell and blank counters SHALL be wide enough for the parameter maxima and SHALL reload at every state entry.

Reset
REQ-026 stop=1 at a clock edge sets state=IDLE, row=0, snap=0, pending=0, counters=0, row_sel=0, col_data=0, frame_done=0 and frame_count=0.
REQ-027 stop has priority over enable and grid_valid in the same cycle.
REQ-028 Reset mid-frame SHALL abort immediately with no frame_done pulse.
REQ-029 The first LOAD after reset always snapshots grid.

Configuration
REQ-030 Macro SCAN_BRIGHTNESS_EN defined: adds input brightness [2:0]. Within SCAN, col_data is forced to 0 when (dwell_cnt mod 8) >= brightness+1, where dwell_cnt is 0 on the first SCAN cycle; brightness=7 gives full on. row_sel and all timing are unchanged.
REQ-031 Macro SCAN_BRIGHTNESS_EN undefined: there is no brightness port and col_data is driven for the full DWELL.

Verification
REQ-032 Parameters DWELL=4, BLANK=2; stop pulse then enable=1 with grid=49'h1 -> LOAD at cycle 1; row_sel=7'h01 and col_data=7'h01 for 4 cycles; then row_sel=0 for 2 cycles; frame_done at cycle 43 with frame_count=1.
REQ-033 grid=0x7F<<42 (row 6 all on) -> col_data=7'h7F only while row_sel=7'h40; col_data=0 for every other row.
REQ-034 grid_valid pulse with a new grid in mid-frame -> the current frame still shows the old snap; the next frame shows the new grid; a grid change without grid_valid is never displayed.
REQ-035 enable dropped during row 2 -> rows 3..6 complete, frame_done pulses, then IDLE with outputs 0; stop asserted during row 4 of a later frame -> all outputs 0 on the next edge and no frame_done pulse.
REQ-036 BLANK=0 -> row_sel goes 01,02,04 ... 40 with no zero gap; the frame length is 1+7*DWELL cycles; the one-hot checker passes.
REQ-037 With SCAN_BRIGHTNESS_EN defined, DWELL=16, brightness=1 -> col_data is non-zero for 2 of every 8 SCAN cycles; brightness=7 -> col_data is non-zero for all 16 cycles.
